qracc_feature_loader: RTL and testbench
=======================================

# qracc_feature_loader

- Double-buffered window assembler between the activation buffer read port and the QRAcc MAC array.
- The controller streams convolution-window row segments into a fill bank, one row of FX×C elements per fy step, then commits the bank.
- The committed bank is presented to the MAC array as a full numRows-element input vector under a valid/ready handshake.
- Filling of the next window overlaps consumption of the current one.

## Interface
- numRows, 128: elements per window (MAC array rows)
- elemWidth, 8: bits per element
- wrWidth, 128: write data width (internal interface); elemsPerWrite = wrWidth/elemWidth, must divide exactly
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear (csr_main_clear)
- wr_en_i  in  1  write a segment into the fill bank
- wr_addr_i  in  32  element index of the first element of the segment
- wr_data_i  in  wrWidth  packed elements, element k at bits [k*elemWidth +: elemWidth]
- commit_i  in  1  fill bank is a complete window (qracc_mac_data_valid)
- loader_ready_o  out  1  fill bank can accept writes/commit
- window_o  out  numRows*elemWidth  hold-bank contents
- window_valid_o  out  1  hold bank holds an unconsumed window
- window_ready_i  in  1  MAC array accepts window (qracc_ready)
- overflow_o  out  1  sticky: write or commit attempted while not ready

## Operation
- Two banks, bank_sel selects the hold bank; the other is the fill bank.
- Write: for k in 0..elemsPerWrite-1, fill[wr_addr_i+k] <= element k if wr_addr_i+k < numRows; out-of-range elements dropped silently (no overflow).
- Handshake out = window_valid_o && window_ready_i.
- FSM states and transitions:
  - S_EMPTY: no window held.
    - commit → swap, S_HOLD.
  - S_HOLD: hold bank valid, fill bank writable.
    - handshake only → S_EMPTY.
    - commit only → S_FULL, no swap.
    - commit + handshake → swap, stay S_HOLD.
  - S_FULL: both banks hold windows; loader_ready_o=0.
    - handshake → swap, S_HOLD.
- Swap: bank_sel toggles; the bank becoming the fill bank is zeroed, so unwritten positions (padding rows beyond FY·FX·C) read as 0.
- In S_FULL, wr_en_i or commit_i are ignored and set overflow_o.
- Write and commit in the same cycle: the written data is part of the committed window.
- clear_i: state → S_EMPTY, both banks zeroed, bank_sel=0, overflow_o=0. clear_i takes priority over all other inputs.

## Timing
- Reset values:
  - window_o=0, window_valid_o=0, loader_ready_o=1, overflow_o=0.
  - state S_EMPTY, bank_sel=0, banks zero.
- Outputs:
  - window_valid_o = (state != S_EMPTY), registered.
  - loader_ready_o = (state != S_FULL), registered.
- Commit-to-valid latency: 1 cycle; window_o is valid in the same cycle window_valid_o rises.
- window_o and window_valid_o hold stable while valid && !ready.
- Back-to-back commits on consecutive cycles with window_ready_i=1 sustain one window per cycle.
- Reset asserted mid-window discards both banks; no partial window is ever presented.

## Configuration
- QRACC_FEATURE_LOADER_ZERO_FILL_EN defined: the new fill bank is zeroed on every swap, as described above.
- Not defined: no zeroing on swap; the fill bank retains stale contents from two windows earlier.
  - Saves the clear muxes.
  - The controller must then write every position, including padding.
- clear_i and nrst zero the banks in both builds.

## Test plan
- Single window: write 0x01..0x10 at addr 0 and 0x11..0x20 at addr 16, commit, ready=1 → next cycle valid=1, elements 0..31 = 0x01..0x20, elements 32..127 = 0; valid drops after 1 cycle.
- Stall/backpressure:
  - Commit A with ready=0, fill B, commit B → state S_FULL, loader_ready_o=0, window_o=A stable.
  - Raise ready → A accepted, then B presented the next cycle.
- Overflow: in S_FULL, pulse wr_en_i at addr 0 → hold bank unchanged, overflow_o=1 and stays 1 until clear_i.
- Edge addressing: write at wr_addr_i=120 with 16 elements → elements 120..127 written, 8 dropped, overflow_o stays 0.
- Simultaneous events: in S_HOLD, assert commit_i with window_ready_i=1 → next window presented next cycle, valid stays 1, state S_HOLD.
- Clear mid-operation: assert clear_i while in S_FULL → next cycle valid=0, loader_ready_o=1, window_o=0; a subsequent commit with no writes presents an all-zero window.

Source files
------------

// File: rtl/qracc_feature_loader.sv
// Purpose: double-buffered window assembler feeding the QRAcc MAC array input vector.
// Latency: commit to window_valid_o is 1 cycle; window_o is valid the cycle valid rises.
// Backpressure: loader_ready_o drops while both banks hold windows; writes/commits then set sticky overflow_o.
// Option: QRACC_FEATURE_LOADER_ZERO_FILL_EN zeroes the new fill bank on every swap.
module qracc_feature_loader #(
    parameter int NUM_ROWS   = 128,
    parameter int ELEM_WIDTH = 8,
    parameter int WR_WIDTH   = 128
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           clear_i,
    input  logic                           wr_en_i,
    input  logic [31:0]                    wr_addr_i,
    input  logic [WR_WIDTH-1:0]            wr_data_i,
    input  logic                           commit_i,
    output logic                           loader_ready_o,
    output logic [NUM_ROWS*ELEM_WIDTH-1:0] window_o,
    output logic                           window_valid_o,
    input  logic                           window_ready_i,
    output logic                           overflow_o
);

    localparam int EPW    = WR_WIDTH / ELEM_WIDTH;
    localparam int EIDX_W = (EPW > 1) ? $clog2(EPW) : 1;

    if ((WR_WIDTH % ELEM_WIDTH) != 0) begin : g_bad_width
        $error("WR_WIDTH must be a whole number of elements");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state;
    logic   bank_sel;

    // bank[bank_sel] is the hold bank shown to the MAC array, the other is filled
    logic [1:0][NUM_ROWS-1:0][ELEM_WIDTH-1:0] bank;

    logic [EPW-1:0][ELEM_WIDTH-1:0]      wr_elems;
    logic [NUM_ROWS-1:0][ELEM_WIDTH-1:0] wr_vec;
    logic [NUM_ROWS-1:0]                 wr_hit;
    logic                                handshake;
    logic                                wr_ok;
    logic                                swap;

    assign wr_elems  = wr_data_i;
    assign handshake = window_valid_o && window_ready_i;
    assign wr_ok     = wr_en_i && (state != S_FULL);
    assign window_o  = bank[bank_sel];

    // Per-element address decode: element i takes segment element (i - wr_addr_i) when in range.
    // The 33-bit difference wraps to a huge value for i < wr_addr_i, so one compare covers both bounds.
    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_elem
        logic [32:0] off;
        assign off       = 33'(i) - {1'b0, wr_addr_i};
        assign wr_hit[i] = (off < 33'(EPW));
        assign wr_vec[i] = wr_elems[off[EIDX_W-1:0]];
    end

    // Decide when the banks trade roles: a commit that leaves only one window pending,
    // or a handshake out of the full state.
    always_comb begin
        swap = 1'b0;
        case (state)
            S_EMPTY: swap = commit_i;
            S_HOLD:  swap = commit_i && handshake;
            S_FULL:  swap = handshake;
            default: swap = 1'b0;
        endcase
    end

    // Window-tracking FSM with registered valid/ready/overflow outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= S_EMPTY;
            bank_sel       <= 1'b0;
            window_valid_o <= 1'b0;
            loader_ready_o <= 1'b1;
            overflow_o     <= 1'b0;
        end else if (clear_i) begin
            state          <= S_EMPTY;
            bank_sel       <= 1'b0;
            window_valid_o <= 1'b0;
            loader_ready_o <= 1'b1;
            overflow_o     <= 1'b0;
        end else begin
            if (swap) begin
                bank_sel <= ~bank_sel;
            end
            case (state)
                S_EMPTY: begin
                    if (commit_i) begin
                        state          <= S_HOLD;
                        window_valid_o <= 1'b1;
                        loader_ready_o <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (commit_i && !handshake) begin
                        state          <= S_FULL;
                        loader_ready_o <= 1'b0;
                    end else if (!commit_i && handshake) begin
                        state          <= S_EMPTY;
                        window_valid_o <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (wr_en_i || commit_i) begin
                        overflow_o <= 1'b1;
                    end
                    if (handshake) begin
                        state          <= S_HOLD;
                        loader_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_EMPTY;
                    window_valid_o <= 1'b0;
                    loader_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Bank storage: segment writes land in the fill bank; the old hold bank is
    // optionally zeroed as it becomes the next fill bank.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bank <= '0;
        end else if (clear_i) begin
            bank <= '0;
        end else begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                if (wr_ok && wr_hit[i]) begin
                    bank[~bank_sel][i] <= wr_vec[i];
                end
            end
`ifdef QRACC_FEATURE_LOADER_ZERO_FILL_EN
            if (swap) begin
                bank[bank_sel] <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_qracc_feature_loader.sv
// Bench for qracc_feature_loader: windows are modelled as a queue of committed vectors
// plus a fill buffer, and every cycle the DUT outputs are compared against that model.
module tb_qracc_feature_loader;

    localparam int NR   = 128;
    localparam int EW   = 8;
    localparam int WW   = 128;
    localparam int EPW  = WW / EW;
    localparam int WINW = NR * EW;

    typedef logic [WINW-1:0] win_t;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          clear_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [31:0]   wr_addr_i = '0;
    logic [WW-1:0] wr_data_i = '0;
    logic          commit_i = 1'b0;
    logic          window_ready_i = 1'b0;
    logic          loader_ready_o;
    win_t          window_o;
    logic          window_valid_o;
    logic          overflow_o;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model: pending windows in commit order, the buffer being filled, the last
    // committed window (stale source) and the last consumed window (shown when idle).
    win_t mq[$];
    win_t m_fill = '0;
    win_t m_prev = '0;
    win_t m_last = '0;
    bit   m_ovf  = 1'b0;
    win_t exp_w;

    always #5 clk = ~clk;

    qracc_feature_loader #(.NUM_ROWS(NR), .ELEM_WIDTH(EW), .WR_WIDTH(WW)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .clear_i        (clear_i),
        .wr_en_i        (wr_en_i),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .commit_i       (commit_i),
        .loader_ready_o (loader_ready_o),
        .window_o       (window_o),
        .window_valid_o (window_valid_o),
        .window_ready_i (window_ready_i),
        .overflow_o     (overflow_o)
    );

    function automatic logic [WW-1:0] seq_data(input logic [7:0] base);
        logic [WW-1:0] d;
        d = '0;
        for (int k = 0; k < EPW; k++) d[k*EW +: EW] = base + 8'(k);
        return d;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_fill = '0;
        m_prev = '0;
        m_last = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_update();
        bit     hs;
        bit     rdy;
        longint a;
        win_t   committed;
        if (!nrst || clear_i) begin
            model_clear();
            return;
        end
        hs  = (mq.size() > 0) && window_ready_i;
        rdy = (mq.size() < 2);
        if (!rdy) begin
            if (wr_en_i || commit_i) m_ovf = 1'b1;
        end else if (wr_en_i) begin
            for (int k = 0; k < EPW; k++) begin
                a = longint'(wr_addr_i) + longint'(k);
                if (a < NR) m_fill[int'(a)*EW +: EW] = wr_data_i[k*EW +: EW];
            end
        end
        if (hs) m_last = mq.pop_front();
        if (rdy && commit_i) begin
            committed = m_fill;
            mq.push_back(committed);
`ifdef QRACC_FEATURE_LOADER_ZERO_FILL_EN
            m_fill = '0;
`else
            m_fill = m_prev;
`endif
            m_prev = committed;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input win_t act, input win_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int e = 0; e < NR; e++) begin
                if (act[e*EW +: EW] !== exp[e*EW +: EW]) begin
                    $display("FAIL %s elem %0d act=%02h exp=%02h", name, e, act[e*EW +: EW], exp[e*EW +: EW]);
                    break;
                end
            end
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_w = (mq.size() > 0) ? mq[0] : m_last;
            check("window_valid_o", 32'(window_valid_o), 32'(mq.size() > 0));
            check("loader_ready_o", 32'(loader_ready_o), 32'(mq.size() < 2));
            check("overflow_o", 32'(overflow_o), 32'(m_ovf));
            check_win("window_o", window_o, exp_w);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc(input bit wr, input logic [31:0] addr, input logic [WW-1:0] data,
                       input bit cm, input bit rdy, input bit clr);
        wr_en_i        = wr;
        wr_addr_i      = addr;
        wr_data_i      = data;
        commit_i       = cm;
        window_ready_i = rdy;
        clear_i        = clr;
        tick();
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 32'd0, '0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        chk_en = 1'b1;
        idle(1'b0);
        idle(1'b0);
        nrst = 1'b1;
        check("rst_valid", 32'(window_valid_o), 32'd0);
        check("rst_ready", 32'(loader_ready_o), 32'd1);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_window_zero", 32'(window_o == '0), 32'd1);

        // Single window: two segments then commit
        cyc(1'b1, 32'd0, seq_data(8'h01), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'd16, seq_data(8'h11), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, '0, 1'b1, 1'b1, 1'b0);
        check("single_valid", 32'(window_valid_o), 32'd1);
        check("single_e0", 32'(window_o[7:0]), 32'h01);
        check("single_e31", 32'(window_o[255:248]), 32'h20);
        check("single_pad_zero", 32'(window_o[WINW-1:256] == '0), 32'd1);
        idle(1'b1);
        check("single_valid_drop", 32'(window_valid_o), 32'd0);

        // Backpressure: A held, B committed behind it
        cyc(1'b1, 32'd0, seq_data(8'hA0), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'd0, seq_data(8'hB0), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);
        check("full_ready", 32'(loader_ready_o), 32'd0);
        check("full_hold_a", 32'(window_o[7:0]), 32'hA0);
        idle(1'b0);
        check("stall_hold_a", 32'(window_o[7:0]), 32'hA0);
        // Overflow: write in the full state
        cyc(1'b1, 32'd0, seq_data(8'hEE), 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow_o), 32'd1);
        check("ovf_hold_a", 32'(window_o[7:0]), 32'hA0);
        idle(1'b1);
        check("drain_b_valid", 32'(window_valid_o), 32'd1);
        check("drain_b_e0", 32'(window_o[7:0]), 32'hB0);
        idle(1'b1);
        check("ovf_sticky", 32'(overflow_o), 32'd1);

        // Clear, then edge addressing with write+commit in the same cycle
        cyc(1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow_o), 32'd0);
        cyc(1'b1, 32'd120, seq_data(8'h50), 1'b1, 1'b0, 1'b0);
        check("edge_e120", 32'(window_o[967:960]), 32'h50);
        check("edge_e127", 32'(window_o[1023:1016]), 32'h57);
        check("edge_e119", 32'(window_o[959:952]), 32'h00);
        check("edge_no_ovf", 32'(overflow_o), 32'd0);
        idle(1'b1);

        // Commit together with handshake in S_HOLD
        cyc(1'b1, 32'd0, seq_data(8'hC0), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'd0, seq_data(8'hD0), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, '0, 1'b1, 1'b1, 1'b0);
        check("simul_valid", 32'(window_valid_o), 32'd1);
        check("simul_e0", 32'(window_o[7:0]), 32'hD0);
        check("simul_ready", 32'(loader_ready_o), 32'd1);
        idle(1'b1);

        // Clear while full, then an all-zero window
        cyc(1'b1, 32'd0, seq_data(8'h60), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'd0, seq_data(8'h70), 1'b1, 1'b0, 1'b0);
        check("clr_pre_full", 32'(loader_ready_o), 32'd0);
        cyc(1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_valid", 32'(window_valid_o), 32'd0);
        check("clr_ready", 32'(loader_ready_o), 32'd1);
        check("clr_window_zero", 32'(window_o == '0), 32'd1);
        cyc(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);
        check("clr_commit_valid", 32'(window_valid_o), 32'd1);
        check("clr_commit_zero", 32'(window_o == '0), 32'd1);
        idle(1'b1);

        // Back-to-back commits with the consumer always ready
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'(8 * i), seq_data(8'(8'h80 + 16 * i)), 1'b1, 1'b1, 1'b0);
        end
        check("b2b_last_e24", 32'(window_o[199:192]), 32'hB0);
        idle(1'b1);
        check("b2b_drained", 32'(window_valid_o), 32'd0);

        // Asynchronous reset while full
        cyc(1'b1, 32'd0, seq_data(8'h90), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'd0, seq_data(8'hA5), 1'b1, 1'b0, 1'b0);
        nrst = 1'b0;
        model_clear();
        #1;
        check("arst_valid", 32'(window_valid_o), 32'd0);
        check("arst_window_zero", 32'(window_o == '0), 32'd1);
        idle(1'b0);
        nrst = 1'b1;
        cyc(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);
        check("arst_commit_zero", 32'(window_o == '0), 32'd1);
        idle(1'b1);
        idle(1'b1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
